mdio_cfg_seq: RTL and testbench
===============================

MDIO_CFG_SEQ -- requirements
Module: mdio_cfg_seq

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'd1: PHY address placed on every request.
REQ-002 SHALL have parameter POLL_MAX, default 16'd1000: maximum reset-poll reads before error.
REQ-003 SHALL have parameter GAP_CYC, default 16'd100: idle cycles between consecutive poll reads.
REQ-004 SHALL have parameter DONE_TO, default 16'd4096: cycles allowed per frame from request to mdio_done.
REQ-005 SHALL have port sys_clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port sys_rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port cfg_start_flag  input  1  one-cycle pulse that starts the configuration sequence.
REQ-008 SHALL have port mdio_req  output  1  one-cycle start pulse to the downstream MDIO frame engine (its start-flag input).
REQ-009 SHALL have port mdio_op  output  1  1 = write frame, 0 = read frame.
REQ-010 SHALL have port mdio_phy_addr  output  5  PHY address of the current frame.
REQ-011 SHALL have port mdio_reg_addr  output  5  register address of the current frame.
REQ-012 SHALL have port mdio_wr_data  output  16  write payload; 16'h0000 on reads.
REQ-013 SHALL have port mdio_done  input  1  one-cycle pulse from the engine at frame completion.
REQ-014 SHALL have port mdio_rd_data  input  16  read result; valid only in the mdio_done cycle of a read.
REQ-015 SHALL have port cfg_busy  output  1  high from the cycle after an accepted start until the end of the sequence.
REQ-016 SHALL have port cfg_done  output  1  one-cycle pulse at sequence end (success or error).
REQ-017 SHALL have port cfg_err  output  1  error flag; held until the next accepted start.
REQ-018 SHALL have port err_code  output  2  00 none, 01 frame timeout, 10 poll exhausted.
REQ-019 SHALL have port phy_status  output  16  last value read from register 1.

Function
REQ-020 SHALL execute fixed steps in order: S0 write reg0=16'h8000; S1 read reg0 (poll); S2 write reg4=16'h01E1; S3 write reg0=16'h1200; S4 read reg1.
REQ-021 SHALL implement states IDLE, ISSUE, WAIT, GAP, FIN, with a 3-bit step index.
REQ-022 SHALL move IDLE->ISSUE on cfg_start_flag; cfg_busy=1 and cfg_err/err_code cleared from the next cycle; step index=0.
REQ-023 SHALL assert mdio_req for exactly the one cycle spent in ISSUE, then enter WAIT; mdio_req is registered, first pulse is the cycle after cfg_start_flag.
REQ-024 SHALL hold mdio_op/phy/reg/wr_data stable from the ISSUE cycle through the mdio_done cycle.
REQ-025 SHALL, on mdio_done in WAIT for S0/S2/S3, advance the step index and enter ISSUE next cycle (next mdio_req one cycle after mdio_done).
REQ-026 SHALL, on mdio_done in WAIT for S1: if mdio_rd_data[15]==0 advance to S2 via ISSUE; else increment poll count and enter GAP.
REQ-027 SHALL stay in GAP exactly GAP_CYC cycles, then ISSUE repeating S1.
REQ-028 SHALL, when the poll count reaches POLL_MAX with bit15 still 1, set err_code=10 and enter FIN without further requests.
REQ-029 SHALL count cycles in WAIT; if DONE_TO cycles pass without mdio_done, set err_code=01 and enter FIN.
REQ-030 SHALL, on mdio_done in WAIT for S4, load phy_status with mdio_rd_data and enter FIN.
REQ-031 SHALL in FIN pulse cfg_done for one cycle, set cfg_err=1 iff err_code!=00, drop cfg_busy, and return to IDLE.
REQ-032 SHALL ignore cfg_start_flag in any state other than IDLE.
REQ-033 SHALL ignore mdio_done outside WAIT, including one coinciding with the ISSUE cycle.
REQ-034 SHALL use saturating 16-bit poll and timeout counters cleared on each ISSUE entry (timeout) or sequence start (poll).

Reset
REQ-035 SHALL, while sys_rst=1, force state IDLE, step 0, counters 0, mdio_req=0, mdio_op=0, mdio_phy_addr=0, mdio_reg_addr=0, mdio_wr_data=0, cfg_busy=0, cfg_done=0, cfg_err=0, err_code=00, phy_status=16'h0000.
REQ-036 SHALL abandon any in-progress sequence on reset with no cfg_done pulse; a late mdio_done after reset is ignored.

Verification
REQ-037 Nominal: start pulse, engine model returns done 40 cycles after each req, reg0 reads 16'h0000, reg1 reads 16'h796D -> 5 reqs in S0..S4 order, cfg_done once, cfg_err=0, phy_status=16'h796D.
REQ-038 Poll: reg0 reads 16'h8000 twice then 16'h1140 -> three S1 reads, each pair separated by GAP_CYC idle cycles, sequence completes without error.
REQ-039 Poll exhaust (POLL_MAX=3): reg0 always 16'h8000 -> exactly 3 S1 reads, no S2 request, cfg_done pulse, cfg_err=1, err_code=10.
REQ-040 Timeout (DONE_TO=64): engine never answers S2 -> cfg_done 64 cycles after the S2 req, err_code=01, no further req.
REQ-041 Start while busy, and spurious mdio_done in IDLE -> no effect on sequence or outputs.
REQ-042 Reset asserted during S1 GAP -> all outputs at reset values next cycle; fresh start then runs the nominal sequence from S0.

Source files
------------

// File: rtl/mdio_cfg_seq.sv
// mdio_cfg_seq
//   Drives a fixed PHY bring-up sequence through an external MDIO frame engine:
//     S0 write reg0 = 16'h8000   (soft reset)
//     S1 read  reg0              (poll until bit15 / reset-in-progress clears)
//     S2 write reg4 = 16'h01E1   (autoneg advertisement)
//     S3 write reg0 = 16'h1200   (enable + restart autoneg)
//     S4 read  reg1              (capture status)
//   Each frame is a one-cycle mdio_req with stable op/address/data, completed
//   by a one-cycle mdio_done from the engine. Each frame has its own timeout.
//   The reset poll has an inter-read gap and a retry limit.
//
// Ports
//   sys_clk, sys_rst        : clock, synchronous active-high reset
//   cfg_start_flag          : one-cycle start pulse (accepted only when idle)
//   mdio_req                : one-cycle frame request to the engine
//   mdio_op                 : 1 = write, 0 = read
//   mdio_phy_addr/reg_addr  : frame addressing
//   mdio_wr_data            : write payload (zero for reads)
//   mdio_done, mdio_rd_data : frame completion pulse and read result
//   cfg_busy                : sequence in progress
//   cfg_done                : one-cycle end-of-sequence pulse
//   cfg_err, err_code       : error flag / cause (01 timeout, 10 poll exhausted)
//   phy_status              : last value read from register 1
module mdio_cfg_seq #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [15:0] POLL_MAX = 16'd1000,
  parameter logic [15:0] GAP_CYC  = 16'd100,
  parameter logic [15:0] DONE_TO  = 16'd4096
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cfg_start_flag,
  output logic        mdio_req,
  output logic        mdio_op,
  output logic [4:0]  mdio_phy_addr,
  output logic [4:0]  mdio_reg_addr,
  output logic [15:0] mdio_wr_data,
  input  logic        mdio_done,
  input  logic [15:0] mdio_rd_data,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [1:0]  err_code,
  output logic [15:0] phy_status
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  localparam logic [2:0] STEP_RST     = 3'd0;
  localparam logic [2:0] STEP_POLL    = 3'd1;
  localparam logic [2:0] STEP_ANEG    = 3'd2;
  localparam logic [2:0] STEP_RESTART = 3'd3;
  localparam logic [2:0] STEP_STAT    = 3'd4;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_POLL    = 2'b10;

  state_t      state_reg, state_next;
  logic [2:0]  step_reg, step_next;
  logic [15:0] poll_cnt_reg, poll_cnt_next;
  logic [15:0] to_cnt_reg, to_cnt_next;
  logic [15:0] gap_cnt_reg, gap_cnt_next;

  logic        req_reg, req_next;
  logic        op_reg, op_next;
  logic [4:0]  phy_reg, phy_next;
  logic [4:0]  addr_reg, addr_next;
  logic [15:0] wdata_reg, wdata_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  logic [1:0]  code_reg, code_next;
  logic [15:0] status_reg, status_next;

  // Frame contents of the step about to be issued.
  logic        step_op;
  logic [4:0]  step_addr;
  logic [15:0] step_data;

  logic [15:0] poll_inc;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign poll_inc = sat_inc(poll_cnt_reg);

  always_comb begin
    step_op   = 1'b0;
    step_addr = 5'd0;
    step_data = 16'h0000;
    case (step_next)
      STEP_RST: begin
        step_op   = 1'b1;
        step_addr = 5'd0;
        step_data = 16'h8000;
      end
      STEP_POLL: begin
        step_op   = 1'b0;
        step_addr = 5'd0;
      end
      STEP_ANEG: begin
        step_op   = 1'b1;
        step_addr = 5'd4;
        step_data = 16'h01E1;
      end
      STEP_RESTART: begin
        step_op   = 1'b1;
        step_addr = 5'd0;
        step_data = 16'h1200;
      end
      STEP_STAT: begin
        step_op   = 1'b0;
        step_addr = 5'd1;
      end
      default: begin
        step_op   = 1'b0;
        step_addr = 5'd0;
      end
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    step_next     = step_reg;
    poll_cnt_next = poll_cnt_reg;
    to_cnt_next   = to_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    busy_next     = busy_reg;
    err_next      = err_reg;
    code_next     = code_reg;
    status_next   = status_reg;

    case (state_reg)
      ST_IDLE: begin
        if (cfg_start_flag) begin
          state_next    = ST_ISSUE;
          step_next     = STEP_RST;
          poll_cnt_next = 16'd0;
          busy_next     = 1'b1;
          err_next      = 1'b0;
          code_next     = ERR_NONE;
        end
      end

      ST_ISSUE: begin
        // The request cycle is cycle 0 of the frame's timeout window.
        state_next  = ST_WAIT;
        to_cnt_next = sat_inc(to_cnt_reg);
      end

      ST_WAIT: begin
        if (mdio_done) begin
          case (step_reg)
            STEP_POLL: begin
              if (!mdio_rd_data[15]) begin
                step_next  = STEP_ANEG;
                state_next = ST_ISSUE;
              end else begin
                poll_cnt_next = poll_inc;
                if (poll_inc >= POLL_MAX) begin
                  code_next  = ERR_POLL;
                  state_next = ST_FIN;
                end else if (GAP_CYC == 16'd0) begin
                  state_next = ST_ISSUE;
                end else begin
                  gap_cnt_next = 16'd0;
                  state_next   = ST_GAP;
                end
              end
            end
            STEP_STAT: begin
              status_next = mdio_rd_data;
              state_next  = ST_FIN;
            end
            default: begin
              step_next  = step_reg + 3'd1;
              state_next = ST_ISSUE;
            end
          endcase
        end else if (to_cnt_reg >= DONE_TO - 16'd1) begin
          // Window exhausted: the next cycle would be DONE_TO after the request.
          code_next  = ERR_TIMEOUT;
          state_next = ST_FIN;
        end else begin
          to_cnt_next = sat_inc(to_cnt_reg);
        end
      end

      ST_GAP: begin
        if (gap_cnt_reg >= GAP_CYC - 16'd1) begin
          state_next = ST_ISSUE;
        end else begin
          gap_cnt_next = sat_inc(gap_cnt_reg);
        end
      end

      ST_FIN: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (state_next == ST_ISSUE) begin
      to_cnt_next = 16'd0;
    end

    if (state_next == ST_FIN) begin
      busy_next = 1'b0;
      err_next  = (code_next != ERR_NONE);
    end
  end

  // Registered frame outputs: loaded on ISSUE entry, held through the frame.
  always_comb begin
    req_next   = (state_next == ST_ISSUE);
    done_next  = (state_next == ST_FIN);
    op_next    = op_reg;
    phy_next   = phy_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    if (state_next == ST_ISSUE) begin
      op_next    = step_op;
      phy_next   = PHY_ADDR;
      addr_next  = step_addr;
      wdata_next = step_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg    <= ST_IDLE;
      step_reg     <= STEP_RST;
      poll_cnt_reg <= 16'd0;
      to_cnt_reg   <= 16'd0;
      gap_cnt_reg  <= 16'd0;
      req_reg      <= 1'b0;
      op_reg       <= 1'b0;
      phy_reg      <= 5'd0;
      addr_reg     <= 5'd0;
      wdata_reg    <= 16'h0000;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      code_reg     <= ERR_NONE;
      status_reg   <= 16'h0000;
    end else begin
      state_reg    <= state_next;
      step_reg     <= step_next;
      poll_cnt_reg <= poll_cnt_next;
      to_cnt_reg   <= to_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      req_reg      <= req_next;
      op_reg       <= op_next;
      phy_reg      <= phy_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      code_reg     <= code_next;
      status_reg   <= status_next;
    end
  end

  assign mdio_req      = req_reg;
  assign mdio_op       = op_reg;
  assign mdio_phy_addr = phy_reg;
  assign mdio_reg_addr = addr_reg;
  assign mdio_wr_data  = wdata_reg;
  assign cfg_busy      = busy_reg;
  assign cfg_done      = done_reg;
  assign cfg_err       = err_reg;
  assign err_code      = code_reg;
  assign phy_status    = status_reg;

endmodule

// File: tb/tb_mdio_cfg_seq.sv
// Testbench for mdio_cfg_seq: an MDIO engine model answers requests after a
// fixed latency with scripted register contents, an event-level model of the
// configuration sequence predicts every output each cycle, and directed
// scenarios add hand-computed literal checks.
module tb_mdio_cfg_seq;
  localparam logic [4:0] PHY = 5'h13;
  localparam int POLL_N = 3;
  localparam int GAP_N  = 10;
  localparam int DTO_N  = 64;
  localparam int LAT    = 40;

  logic        clk = 1'b0;
  logic        rst, start, done;
  logic [15:0] rd;
  logic        mdio_req, mdio_op;
  logic [4:0]  mdio_phy_addr, mdio_reg_addr;
  logic [15:0] mdio_wr_data;
  logic        cfg_busy, cfg_done, cfg_err;
  logic [1:0]  err_code;
  logic [15:0] phy_status;

  mdio_cfg_seq #(
    .PHY_ADDR(PHY),
    .POLL_MAX(16'd3),
    .GAP_CYC (16'd10),
    .DONE_TO (16'd64)
  ) u_dut (
    .sys_clk       (clk),
    .sys_rst       (rst),
    .cfg_start_flag(start),
    .mdio_req      (mdio_req),
    .mdio_op       (mdio_op),
    .mdio_phy_addr (mdio_phy_addr),
    .mdio_reg_addr (mdio_reg_addr),
    .mdio_wr_data  (mdio_wr_data),
    .mdio_done     (done),
    .mdio_rd_data  (rd),
    .cfg_busy      (cfg_busy),
    .cfg_done      (cfg_done),
    .cfg_err       (cfg_err),
    .err_code      (err_code),
    .phy_status    (phy_status)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Step list: S0..S4 as (op, register, payload).
  logic        s_op  [0:4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [4:0]  s_reg [0:4] = '{5'd0, 5'd0, 5'd4, 5'd0, 5'd1};
  logic [15:0] s_wd  [0:4] = '{16'h8000, 16'h0000, 16'h01E1, 16'h1200, 16'h0000};

  // Sequence model (event scheduled in absolute cycles).
  bit          m_idle = 1'b1;
  bit          m_in_fin = 1'b0;
  bit          m_out = 1'b0;
  bit          m_fchk = 1'b0;
  int          m_step = 0;
  int          m_poll = 0;
  int          m_req_at = -1;
  int          m_r = -1;
  logic        e_req, e_done, e_busy, e_err, e_op;
  logic [1:0]  e_code;
  logic [15:0] e_status, e_wd;
  logic [4:0]  e_reg, e_phy;

  // Engine model.
  bit          spur = 1'b0;
  bit          mute4 = 1'b0;
  bit          eng_pend = 1'b0;
  int          eng_at = 0;
  logic [15:0] eng_rd = 16'h0000;
  logic [15:0] r0_q[$];
  logic [15:0] r0_tail = 16'h0000;
  logic [15:0] r1_val = 16'h0000;

  // Request log and completion bookkeeping.
  int          log_cyc [0:63];
  logic [4:0]  log_reg [0:63];
  logic        log_op  [0:63];
  int          log_n = 0;
  int          done_cnt = 0;
  int          last_done_cyc = -1;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic m_finish();
    e_done   = 1'b1;
    e_busy   = 1'b0;
    e_err    = (e_code != 2'b00);
    m_in_fin = 1'b1;
    m_req_at = -1;
  endtask

  // Called at each rising edge with the inputs that edge samples.
  task automatic model_edge();
    bit prev_idle;
    prev_idle = m_idle;
    if (m_in_fin) begin
      m_idle   = 1'b1;
      m_in_fin = 1'b0;
    end
    e_req  = 1'b0;
    e_done = 1'b0;
    if (rst) begin
      m_idle = 1'b1; m_in_fin = 1'b0; m_out = 1'b0; m_req_at = -1; m_fchk = 1'b1;
      e_busy = 1'b0; e_err = 1'b0; e_code = 2'b00; e_status = 16'h0000;
      e_op = 1'b0; e_reg = 5'd0; e_wd = 16'h0000; e_phy = 5'd0;
    end else if (prev_idle) begin
      if (start) begin
        m_idle = 1'b0; e_busy = 1'b1; e_err = 1'b0; e_code = 2'b00;
        m_poll = 0; m_step = 0; m_req_at = cyc;
      end
    end else if (m_out) begin
      // A completion only counts once the request cycle is over.
      if (done && cyc >= m_r + 2) begin
        m_out = 1'b0; m_fchk = 1'b0;
        case (m_step)
          1: begin
            if (!rd[15]) begin
              m_step = 2; m_req_at = cyc;
            end else begin
              m_poll++;
              if (m_poll >= POLL_N) begin
                e_code = 2'b10; m_finish();
              end else begin
                m_req_at = cyc + GAP_N;
              end
            end
          end
          4: begin
            e_status = rd; m_finish();
          end
          default: begin
            m_step++; m_req_at = cyc;
          end
        endcase
      end else if (cyc == m_r + DTO_N) begin
        m_out = 1'b0; m_fchk = 1'b0;
        e_code = 2'b01; m_finish();
      end
    end
    if (!rst && m_req_at == cyc) begin
      e_req = 1'b1; m_out = 1'b1; m_r = cyc; m_fchk = 1'b1; m_req_at = -1;
      e_op = s_op[m_step]; e_reg = s_reg[m_step]; e_wd = s_wd[m_step]; e_phy = PHY;
    end
  endtask

  task automatic compare();
    cmp("mdio_req", {15'd0, mdio_req}, {15'd0, e_req});
    cmp("cfg_done", {15'd0, cfg_done}, {15'd0, e_done});
    cmp("cfg_busy", {15'd0, cfg_busy}, {15'd0, e_busy});
    cmp("cfg_err", {15'd0, cfg_err}, {15'd0, e_err});
    cmp("err_code", {14'd0, err_code}, {14'd0, e_code});
    cmp("phy_status", phy_status, e_status);
    if (m_fchk) begin
      cmp("mdio_op", {15'd0, mdio_op}, {15'd0, e_op});
      cmp("mdio_reg_addr", {11'd0, mdio_reg_addr}, {11'd0, e_reg});
      cmp("mdio_phy_addr", {11'd0, mdio_phy_addr}, {11'd0, e_phy});
      cmp("mdio_wr_data", mdio_wr_data, e_wd);
    end
    if (cfg_done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
  endtask

  task automatic engine();
    done = 1'b0;
    rd   = 16'hDEAD;
    if (spur) begin
      done = 1'b1; rd = 16'hFFFF; spur = 1'b0;
    end
    if (eng_pend && cyc == eng_at) begin
      done = 1'b1; rd = eng_rd; eng_pend = 1'b0;
    end
    if (mdio_req === 1'b1) begin
      if (log_n < 64) begin
        log_cyc[log_n] = cyc; log_reg[log_n] = mdio_reg_addr; log_op[log_n] = mdio_op;
        log_n++;
      end
      if (!(mute4 && mdio_op && mdio_reg_addr == 5'd4)) begin
        eng_pend = 1'b1;
        eng_at   = cyc + LAT;
        eng_rd   = 16'h0000;
        if (!mdio_op && mdio_reg_addr == 5'd0) begin
          if (r0_q.size() > 0) eng_rd = r0_q.pop_front();
          else eng_rd = r0_tail;
        end else if (!mdio_op && mdio_reg_addr == 5'd1) begin
          eng_rd = r1_val;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    compare();
    engine();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_fin(input int budget, input string tag);
    int c0;
    int n;
    c0 = done_cnt;
    n  = 0;
    while (done_cnt == c0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (done_cnt == c0) begin
      errors++;
      $display("FAIL %s no cfg_done within %0d cycles", tag, budget);
    end
  endtask

  function automatic int count_reqs(input logic [4:0] r, input logic op);
    int n;
    n = 0;
    for (int i = 0; i < log_n; i++)
      if (log_reg[i] == r && log_op[i] == op) n++;
    return n;
  endfunction

  function automatic int find_req(input logic [4:0] r, input logic op, input int nth);
    int k;
    k = 0;
    for (int i = 0; i < log_n; i++) begin
      if (log_reg[i] == r && log_op[i] == op) begin
        if (k == nth) return log_cyc[i];
        k++;
      end
    end
    return -1;
  endfunction

  task automatic new_run();
    log_n = 0;
    done_cnt = 0;
    r0_q.delete();
  endtask

  initial begin
    int exp_regs [0:4];
    int n;
    exp_regs = '{0, 0, 4, 0, 1};
    rst = 1'b1; start = 1'b0; done = 1'b0; rd = 16'hDEAD;
    e_req = 1'b0; e_done = 1'b0; e_busy = 1'b0; e_err = 1'b0; e_op = 1'b0;
    e_code = 2'b00; e_status = 16'h0000; e_wd = 16'h0000; e_reg = 5'd0; e_phy = 5'd0;

    repeat (3) tick();
    chk("rst_busy", int'(cfg_busy), 0);
    chk("rst_req", int'(mdio_req), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Spurious completion while idle, then nominal run with a start while busy.
    spur = 1'b1;
    repeat (3) tick();
    chk("spur_idle_busy", int'(cfg_busy), 0);
    new_run();
    r0_q.push_back(16'h0000);
    r1_val = 16'h796D;
    pulse_start();
    repeat (100) tick();
    pulse_start();
    wait_fin(400, "nominal");
    chk("nom_reqs", log_n, 5);
    for (int i = 0; i < 5; i++) chk("nom_order", int'(log_reg[i]), exp_regs[i]);
    chk("nom_spacing", log_cyc[1] - log_cyc[0], LAT + 1);
    chk("nom_err", int'(cfg_err), 0);
    chk("nom_status", int'(phy_status), 16'h796D);
    repeat (5) tick();
    chk("nom_done_once", done_cnt, 1);

    // Reset poll: two busy reads, then clear.
    new_run();
    r0_q.push_back(16'h8000);
    r0_q.push_back(16'h8000);
    r0_q.push_back(16'h1140);
    r1_val = 16'h7949;
    pulse_start();
    wait_fin(600, "poll");
    chk("poll_s1_reads", count_reqs(5'd0, 1'b0), 3);
    chk("poll_gap", find_req(5'd0, 1'b0, 1) - find_req(5'd0, 1'b0, 0), LAT + GAP_N + 1);
    chk("poll_err", int'(cfg_err), 0);
    chk("poll_status", int'(phy_status), 16'h7949);
    repeat (5) tick();

    // Poll exhausted.
    new_run();
    r0_tail = 16'h8000;
    pulse_start();
    wait_fin(600, "exhaust");
    chk("exh_s1_reads", count_reqs(5'd0, 1'b0), 3);
    chk("exh_no_s2", count_reqs(5'd4, 1'b1), 0);
    chk("exh_code", int'(err_code), 2);
    tick();
    chk("exh_err_held", int'(cfg_err), 1);
    repeat (5) tick();
    chk("exh_no_more_req", log_n, 4);

    // Frame timeout on S2.
    new_run();
    r0_tail = 16'h0000;
    mute4 = 1'b1;
    pulse_start();
    wait_fin(600, "timeout");
    chk("to_latency", last_done_cyc - find_req(5'd4, 1'b1, 0), DTO_N);
    chk("to_code", int'(err_code), 1);
    repeat (80) tick();
    chk("to_no_more_req", log_n, 3);
    chk("to_done_once", done_cnt, 1);
    mute4 = 1'b0;

    // Reset during the S1 gap, then a fresh nominal run.
    new_run();
    r0_tail = 16'h8000;
    n = 0;
    pulse_start();
    while (log_n < 2 && n < 200) begin
      tick();
      n++;
    end
    chk("rg_reached_s1", log_n, 2);
    repeat (45) tick();
    rst = 1'b1;
    tick();
    chk("rg_busy", int'(cfg_busy), 0);
    chk("rg_status", int'(phy_status), 0);
    chk("rg_reg_addr", int'(mdio_reg_addr), 0);
    rst = 1'b0;
    repeat (3) tick();
    chk("rg_no_done", done_cnt, 0);
    new_run();
    r0_tail = 16'h0000;
    r1_val = 16'h796D;
    pulse_start();
    wait_fin(400, "post_reset");
    chk("pr_reqs", log_n, 5);
    chk("pr_first_reg", int'(log_reg[0]), 0);
    chk("pr_first_op", int'(log_op[0]), 1);
    chk("pr_status", int'(phy_status), 16'h796D);
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
